// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues RAM fetches, buffers returned words in a prefetch FIFO.
// Define IFU_PC_TAG_EN to tag every buffered word with its fetch address and expose it on instr_pc.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] fetch_address,
    input  logic [DATA_W-1:0] fetch_out,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target
`ifdef IFU_PC_TAG_EN
    ,
    output logic [ADDR_W-1:0] instr_pc
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(DEPTH + MEM_LAT + 1);

    logic              started;
    logic [ADDR_W-1:0] pc;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic              issue;
    logic              push;
    logic              pop;

    // Buffered words plus outstanding requests bound the issue rate so the FIFO can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + OCC_W'(pipe_vld[i]);
        end
        occ = OCC_W'(count) + inflight;
    end

    assign issue         = started && !branch_valid && (occ < OCC_W'(DEPTH));
    assign fetch_en      = issue;
    assign fetch_address = pc;
    assign instr_valid   = (count != '0);
    assign pop           = instr_valid && instr_ready;
    assign push          = pipe_vld[MEM_LAT-1] && !branch_valid;
    assign instr         = instr_valid ? fifo_data[rd_ptr] : '0;

    // Holds off the first request until one full cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (branch_valid) begin
            pc <= branch_target;
        end else if (issue) begin
            pc <= pc + 1'b1;
        end
    end

    // A redirect clears every in-flight marker so late RAM responses are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
        end else if (branch_valid) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= fetch_out;
        end
    end

`ifdef IFU_PC_TAG_EN
    logic [ADDR_W-1:0] pipe_addr [MEM_LAT];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];

    // Address tags travel alongside the in-flight markers and land with their data word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_addr[i] <= RESET_PC;
            end
        end else begin
            pipe_addr[0] <= pc;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr] <= pipe_addr[MEM_LAT-1];
        end
    end

    assign instr_pc = instr_valid ? fifo_pc[rd_ptr] : RESET_PC;
`endif

    assert property (@(posedge clk) disable iff (!reset_n) !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: instance a (MEM_LAT=1, DEPTH=4) and instance b (MEM_LAT=3, DEPTH=8).
// RAM models return 32'hA000_0000 + address; expected words are queued and checked by per-instance monitors.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, fe_a, valid_a, ready_a, br_a;
    logic [15:0] addr_a, tgt_a;
    logic [31:0] ram_a, instr_a;
    logic        rst_b_n, fe_b, valid_b, ready_b, br_b;
    logic [15:0] addr_b, tgt_b;
    logic [31:0] ram_b0, ram_b1, ram_b2, instr_b;
`ifdef IFU_PC_TAG_EN
    logic [15:0] pc_a, pc_b;
`endif

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   issue_cnt_a  = 0;
    int   snap;
    exp_t exp_a [$];
    exp_t exp_b [$];
    exp_t ea, eb;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC(16'h0000)) u_dut_a (
        .clk(clk), .reset_n(rst_a_n), .fetch_en(fe_a), .fetch_address(addr_a), .fetch_out(ram_a),
        .instr(instr_a), .instr_valid(valid_a), .instr_ready(ready_a),
        .branch_valid(br_a), .branch_target(tgt_a)
`ifdef IFU_PC_TAG_EN
        , .instr_pc(pc_a)
`endif
    );

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(32), .DEPTH(8), .MEM_LAT(3), .RESET_PC(16'h0000)) u_dut_b (
        .clk(clk), .reset_n(rst_b_n), .fetch_en(fe_b), .fetch_address(addr_b), .fetch_out(ram_b2),
        .instr(instr_b), .instr_valid(valid_b), .instr_ready(ready_b),
        .branch_valid(br_b), .branch_target(tgt_b)
`ifdef IFU_PC_TAG_EN
        , .instr_pc(pc_b)
`endif
    );

    // RAM models are never reset, so stale responses keep arriving across an IFU reset.
    always @(posedge clk) begin
        if (fe_a) ram_a <= 32'hA000_0000 + {16'h0000, addr_a};
        ram_b0 <= fe_b ? 32'hA000_0000 + {16'h0000, addr_b} : 32'hDEAD_BEEF;
        ram_b1 <= ram_b0;
        ram_b2 <= ram_b1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] actual);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got %h, required no delivery", name, actual);
    endtask

    task automatic push_words(input bit is_b, input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = first + 16'(i);
            e.data = 32'hA000_0000 + {16'h0000, e.pc};
            if (is_b) exp_b.push_back(e);
            else      exp_a.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input logic rdy, input logic br, input logic [15:0] tgt);
        ready_a = rdy;
        br_a    = br;
        tgt_a   = tgt;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_a_n && fe_a) issue_cnt_a++;
        if (rst_a_n && valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                report_unexpected("a_extra_word", instr_a);
            end else begin
                ea = exp_a.pop_front();
                check_output("a_word", instr_a, ea.data);
`ifdef IFU_PC_TAG_EN
                check_output("a_pc", 32'(pc_a), 32'(ea.pc));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b_n && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                report_unexpected("b_extra_word", instr_b);
            end else begin
                eb = exp_b.pop_front();
                check_output("b_word", instr_b, eb.data);
`ifdef IFU_PC_TAG_EN
                check_output("b_pc", 32'(pc_b), 32'(eb.pc));
`endif
            end
        end
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        ready_b = 1'b1;
        br_b    = 1'b0;
        tgt_b   = 16'h0000;
        tick(3);
        check_output("rst_fetch_en", 32'(fe_a), 32'd0);
        check_output("rst_instr_valid", 32'(valid_a), 32'd0);
        check_output("rst_instr", instr_a, 32'd0);
        check_output("rst_fetch_address", 32'(addr_a), 32'd0);

        // Free-running stream from reset, then an asynchronous reset mid-stream
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        push_words(1'b0, 16'h0000, 7);
        rst_a_n = 1'b1;
        #1;
        check_output("t1_fetch_en_cycle1", 32'(fe_a), 32'd0);
        tick(1);
        check_output("t1_fetch_en_cycle2", 32'(fe_a), 32'd1);
        check_output("t1_first_address", 32'(addr_a), 32'd0);
        tick(9);
        rst_a_n = 1'b0;
        #1;
        check_output("t1_reset_fetch_en", 32'(fe_a), 32'd0);
        check_output("t1_reset_instr_valid", 32'(valid_a), 32'd0);
        check_output("t1_reset_instr", instr_a, 32'd0);
        check_output("t1_reset_fetch_address", 32'(addr_a), 32'd0);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick(2);

        // Consumer stalled: exactly DEPTH issues, head held
        rst_a_n = 1'b1;
        snap    = issue_cnt_a;
        tick(8);
        check_output("t2_hold_early", instr_a, 32'hA000_0000);
        check_output("t2_valid_early", 32'(valid_a), 32'd1);
        tick(12);
        check_output("t2_issue_count", 32'(issue_cnt_a - snap), 32'd4);
        check_output("t2_hold_late", instr_a, 32'hA000_0000);
        check_output("t2_fetch_en_stalled", 32'(fe_a), 32'd0);
        push_words(1'b0, 16'h0000, 6);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        tick(6);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick(5);

        // Branch with three words buffered and one in flight
        push_words(1'b0, 16'h0006, 1);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        tick(1);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        check_output("t3_refill_fetch_en", 32'(fe_a), 32'd1);
        check_output("t3_refill_address", 32'(addr_a), 32'd10);
        tick(1);
        apply_stimulus(1'b0, 1'b1, 16'h0040);
        #1;
        check_output("t3_branch_blocks_issue", 32'(fe_a), 32'd0);
        tick(1);
        check_output("t3_flushed", 32'(valid_a), 32'd0);
        check_output("t3_target_address", 32'(addr_a), 32'h0040);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        push_words(1'b0, 16'h0040, 4);
        tick(6);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick(5);

        // PC wrap from 0xFFFE
        apply_stimulus(1'b0, 1'b1, 16'hFFFE);
        tick(1);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        push_words(1'b0, 16'hFFFE, 4);
        tick(6);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick(5);

        // Handshake in a branch cycle, then a second branch the next cycle
        push_words(1'b0, 16'h0002, 1);
        apply_stimulus(1'b1, 1'b1, 16'h0100);
        tick(1);
        check_output("t6_flush_first", 32'(valid_a), 32'd0);
        apply_stimulus(1'b1, 1'b1, 16'h0200);
        tick(1);
        check_output("t6_last_target", 32'(addr_a), 32'h0200);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        push_words(1'b0, 16'h0200, 4);
        tick(6);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        tick(5);
        check_output("a_words_outstanding", 32'(exp_a.size()), 32'd0);

        // Longer latency: reset mid-stream with requests in flight
        push_words(1'b1, 16'h0000, 5);
        rst_b_n = 1'b1;
        tick(10);
        rst_b_n = 1'b0;
        #1;
        check_output("t5_reset_fetch_en", 32'(fe_b), 32'd0);
        check_output("t5_reset_instr_valid", 32'(valid_b), 32'd0);
        check_output("t5_reset_instr", instr_b, 32'd0);
        check_output("t5_reset_fetch_address", 32'(addr_b), 32'd0);
        tick(1);
        push_words(1'b1, 16'h0000, 5);
        rst_b_n = 1'b1;
        tick(10);
        ready_b = 1'b0;
        tick(3);
        check_output("b_words_outstanding", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
